stmt_lowerer_rr_arbiter: RTL
============================

STMT_LOWERER_RR_ARBITER -- requirements
Module: stmt_lowerer_rr_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters; legal range 2..8.
REQ-002 Parameter MAX_HOLD, default 15: maximum number of grant cycles before forced revoke; legal range 1..255.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port req, input, N: request lines, one per requester, level-sensitive.
REQ-006 Port done, input, 1: the current owner releases the resource this cycle.
REQ-007 Port mode, input, 2: arbitration policy.
  - 2'b00 and 2'b11: round-robin.
  - 2'b01: fixed priority, lowest index wins.
  - 2'b10: fixed priority, highest index wins.
REQ-008 Port gnt, output, N: one-hot grant, registered.
REQ-009 Port gnt_id, output, $clog2(N): binary index of the granted requester, registered.
REQ-010 Port gnt_valid, output, 1: high when gnt is nonzero.
REQ-011 Port timeout, output, 1: single-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-012 The arbiter SHALL implement a two-state FSM with states IDLE and OWNED.
REQ-013 In IDLE with req nonzero, the arbiter SHALL select a winner per mode, go to OWNED, and assert gnt/gnt_id on the next edge (latency 1 cycle from req).
REQ-014 Round-robin SHALL search indices last+1, last+2, ... modulo N, stopping at the first set req bit; last resets to N-1.
REQ-015 In OWNED, gnt SHALL stay stable until release.
  - Release occurs on done=1, on timeout, or when req[gnt_id] drops to 0.
  - A dropped req is treated exactly as done.
REQ-016 On release with other requests pending, the arbiter SHALL re-arbitrate in the same cycle and grant the new winner on the next edge, with no idle gap.
  - The releasing requester is excluded from that selection.
REQ-017 On release with no other request pending, the arbiter SHALL return to IDLE with gnt=0.
REQ-018 The last pointer SHALL update to gnt_id on every release, in all modes.
REQ-019 The hold counter (8-bit) SHALL clear on every new grant and increment each OWNED cycle.
  - When it reaches MAX_HOLD without release, the grant is revoked and timeout pulses for exactly 1 cycle.
REQ-020 If done and the hold limit coincide, done SHALL win and timeout SHALL stay 0.
REQ-021 A mode change SHALL take effect only at the next selection; it never preempts a current grant.
REQ-022 req bits at index >= N do not exist; gnt SHALL never have more than one bit set.

Reset
REQ-023 While rst_n=0, the arbiter SHALL hold its reset state, entered asynchronously:
  - FSM=IDLE, gnt=0, gnt_id=0, gnt_valid=0, timeout=0, hold counter=0, last=N-1.
REQ-024 Reset asserted mid-grant SHALL drop gnt immediately, without waiting for a clock edge.
REQ-025 The first selection after reset SHALL behave as if last=N-1.

Structure
REQ-026 Package stmt_lowerer_arb_pkg SHALL hold the following, and the module SHALL import them:
  - the FSM state enum (IDLE, OWNED);
  - mode constants MODE_RR, MODE_LO, MODE_HI;
  - the hold-counter width constant.
REQ-027 Winner selection SHALL be one combinational sub-module, stmt_lowerer_arb_pick.
  - Inputs: req, mask, mode, last. Outputs: found, idx.
  - Written with a case on mode and for loops using break.
REQ-028 The sequential logic SHALL be a single always_ff sensitive to posedge clk or negedge rst_n.

Verification
REQ-029 mode=00, req=4'b1111 held, done pulsed every 2nd grant cycle -> gnt_id sequence 0,1,2,3,0 with no idle cycles between grants.
REQ-030 mode=01, req=4'b1010 -> gnt_id=1; after done -> gnt_id=3; mode=10 with req=4'b0110 -> gnt_id=2.
REQ-031 MAX_HOLD=3, req=4'b0100 held, done=0 -> gnt=4'b0100 for 3 cycles, timeout=1 for one cycle, then re-grant to 2 (the only requester).
REQ-032 done=1 on the exact cycle the counter hits MAX_HOLD -> timeout stays 0, next winner granted.
REQ-033 Owner drops req mid-grant with req=4'b0011 owned by 0 -> next edge gnt=4'b0010.
REQ-034 rst_n pulled low between clock edges while gnt=4'b1000 -> gnt=0 immediately; after release, req=4'b1111 in round-robin -> gnt_id=0.

Source files
------------

// File: rtl/stmt_lowerer_arb_pkg.sv
// Shared FSM state, policy codes and counter width for the statement-lowerer arbiter.
// Latency: n/a (types only); backpressure: n/a.
package stmt_lowerer_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    localparam logic [1:0] MODE_RR = 2'b00;
    localparam logic [1:0] MODE_LO = 2'b01;
    localparam logic [1:0] MODE_HI = 2'b10;

    localparam int HOLD_W = 8;

endpackage

// File: rtl/stmt_lowerer_arb_pick.sv
// Combinational winner select over (req & mask) by policy; RR searches from last+1.
// Latency: 0 cycles; backpressure: none, pure function of its inputs.
module stmt_lowerer_arb_pick
    import stmt_lowerer_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [1:0]    mode,
    input  logic [IW-1:0] last,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [N-1:0]  cand;
    logic [IW-1:0] j;

    assign cand = req & mask;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = '0;
        case (mode)
            MODE_LO: begin
                for (int i = 0; i < N; i++) begin
                    if (cand[i]) begin
                        found = 1'b1;
                        idx   = IW'(i);
                        break;
                    end
                end
            end
            MODE_HI: begin
                for (int i = N - 1; i >= 0; i--) begin
                    if (cand[i]) begin
                        found = 1'b1;
                        idx   = IW'(i);
                        break;
                    end
                end
            end
            default: begin
                // MODE_RR and the spare 2'b11 code both rotate.
                for (int k = 1; k <= N; k++) begin
                    j = IW'((int'(last) + k) % N);
                    if (cand[j]) begin
                        found = 1'b1;
                        idx   = j;
                        break;
                    end
                end
            end
        endcase
    end

endmodule

// File: rtl/stmt_lowerer_rr_arbiter.sv
// N-way arbiter (RR / fixed-lo / fixed-hi) with hold limit and back-to-back re-grant.
// Latency: 1 cycle req->gnt; backpressure: requesters hold req until granted, owner releases via done or dropping req.
module stmt_lowerer_rr_arbiter
    import stmt_lowerer_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 15,
    localparam int IW      = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          done,
    input  logic [1:0]    mode,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id,
    output logic          gnt_valid,
    output logic          timeout
);

    arb_state_t        state_q, state_d;
    logic [N-1:0]      gnt_q, gnt_d;
    logic [IW-1:0]     gnt_id_q, gnt_id_d;
    logic [IW-1:0]     last_q, last_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              timeout_q, timeout_d;

    logic [HOLD_W-1:0] hold_inc;
    logic              owner_req;
    logic              hold_hit;
    logic              release_own;
    logic              expire;
    logic [N-1:0]      pick_mask;
    logic [IW-1:0]     pick_last;
    logic              pick_found;
    logic [IW-1:0]     pick_idx;

    assign hold_inc    = hold_q + 1'b1;
    assign owner_req   = req[gnt_id_q];
    assign hold_hit    = (hold_inc == HOLD_W'(MAX_HOLD));
    assign release_own = done || !owner_req || hold_hit;
    // A voluntary release (done or dropped req) on the limit cycle suppresses timeout.
    assign expire      = hold_hit && !done && owner_req;

    // While owned, the releasing owner is excluded and becomes the RR reference.
    assign pick_mask = (state_q == OWNED) ? ~(N'(1) << gnt_id_q) : {N{1'b1}};
    assign pick_last = (state_q == OWNED) ? gnt_id_q : last_q;

    stmt_lowerer_arb_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req   (req),
        .mask  (pick_mask),
        .mode  (mode),
        .last  (pick_last),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        last_d    = last_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d  = OWNED;
                    gnt_d    = N'(1) << pick_idx;
                    gnt_id_d = pick_idx;
                    hold_d   = '0;
                end
            end
            OWNED: begin
                if (release_own) begin
                    last_d    = gnt_id_q;
                    timeout_d = expire;
                    hold_d    = '0;
                    if (pick_found) begin
                        gnt_d    = N'(1) << pick_idx;
                        gnt_id_d = pick_idx;
                    end else begin
                        state_d  = IDLE;
                        gnt_d    = '0;
                        gnt_id_d = '0;
                    end
                end else begin
                    hold_d = hold_inc;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            last_q    <= IW'(N - 1);
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = |gnt_q;
    assign timeout   = timeout_q;

endmodule
